// File: rtl/alu_tx_pkg.sv
// Shared types and frame constants for the serial ALU result transmitter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package alu_tx_pkg;

  // Frame phases in transmission order; IDLE holds the line high between frames.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SEL    = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam int   FRAME_BITS = 14;
  localparam int   SEL_W      = 3;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Line level driven while in a given phase. Payload phases send the current
  // shift-register LSB; the parity phase sends the precomputed parity bit.
  function automatic logic line_level(input tx_state_e st,
                                      input logic      payload_bit,
                                      input logic      parity_bit);
    logic lvl;
    lvl = STOP_BIT;
    case (st)
      START:     lvl = START_BIT;
      SEL, DATA: lvl = payload_bit;
      PARITY:    lvl = parity_bit;
      default:   lvl = STOP_BIT;  // IDLE and STOP both hold the line high
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// Valid/ready request bus carrying one ALU result and its operation select.
// Latency: n/a (wires only).
// Backpressure: source holds in_valid/in_data/in_sel until it sees in_ready.
interface alu_result_tx_if
  import alu_tx_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;

  modport master (
    output in_valid,
    output in_data,
    output in_sel,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sel,
    output in_ready
  );

endinterface

// File: rtl/alu_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
// Latency: bit_end is high on the last cycle of every CLKS_PER_BIT-cycle bit.
// Backpressure: none; clear holds the count at 0 (used while the line is idle).
module alu_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign bit_end = (cnt_q == LAST);

  // bit_end_next lets the parent register outputs that must line up with bit_end.
  assign bit_end_next = (cnt_d == LAST);

  // Next count: reload 0 on a bit boundary or while cleared, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Serialises {sel, data} LSB-first as start, 3 sel, 8 data, even parity, stop.
// Latency: start bit on the line the cycle after the accepting edge; 14*CLKS_PER_BIT-cycle frame.
// Backpressure: in_ready only while idle and out of reset; at most one frame in flight.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int          DATA_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  alu_result_tx_if.slave  in_if,
  output logic            tx_out,
  output logic            tx_busy,
  output logic            frame_done
);

  localparam int SHIFT_W = SEL_W + DATA_W;
  // Wide enough to index any position in the frame; only 0..DATA_W-1 is used.
  localparam int IDX_W   = $clog2(FRAME_BITS);

  tx_state_e          state_q, state_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic               parity_q, parity_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               tx_out_q, tx_out_d;
  logic               tx_busy_q, tx_busy_d;
  logic               frame_done_q, frame_done_d;

  logic               bit_end;
  logic               bit_end_next;
  logic               timer_clear;
  logic               xfer;
  logic [SHIFT_W-1:0] capture_dat;

  // Ready is gated by rst directly so nothing is accepted during a reset cycle.
  assign in_if.in_ready = (state_q == IDLE) && !rst;
  assign xfer           = in_if.in_valid && in_if.in_ready;

  // sel sits in the low bits so it leaves the shift register first.
  assign capture_dat    = {in_if.in_data, in_if.in_sel};

  // Keep the period counter at 0 while idle so a frame starts on a fresh bit.
  assign timer_clear    = (state_q == IDLE);

  alu_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (timer_clear),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );

  // Frame sequencing, payload shifting and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d   = START;
          shreg_d   = capture_dat;
          parity_d  = ^capture_dat;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = SEL;
          bit_idx_d = '0;
        end
      end
      SEL: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_W'(SEL_W - 1)) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            state_d   = PARITY;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from next-state values so the flops present them
    // in the same cycle the FSM enters the corresponding phase.
    tx_out_d     = line_level(state_d, shreg_d[0], parity_d);
    tx_busy_d    = (state_d != IDLE);
    frame_done_d = (state_d == STOP) && bit_end_next;
  end

  // State, payload and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      bit_idx_q    <= '0;
      tx_out_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      bit_idx_q    <= bit_idx_d;
      tx_out_q     <= tx_out_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
// Expected line levels come from a frame model built directly from the bit layout.
module tb_alu_result_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic tx_out4, tx_busy4, fd4;
  logic tx_out1, tx_busy1, fd1;

  alu_result_tx_if #(.DATA_W(8)) if4 ();
  alu_result_tx_if #(.DATA_W(8)) if1 ();

  alu_result_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_if      (if4.slave),
    .tx_out     (tx_out4),
    .tx_busy    (tx_busy4),
    .frame_done (fd4)
  );

  alu_result_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_if      (if1.slave),
    .tx_out     (tx_out1),
    .tx_busy    (tx_busy1),
    .frame_done (fd1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame as transmitted, index 0 first on the line.
  function automatic logic [13:0] model_frame(input logic [2:0] s, input logic [7:0] d);
    logic [13:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 3; i++) f[1 + i] = s[i];
    for (int i = 0; i < 8; i++) f[4 + i] = d[i];
    f[12] = (($countones({s, d}) % 2) == 1);
    f[13] = 1'b1;
    return f;
  endfunction

  task automatic set_in(input int which, input logic v, input logic [2:0] s, input logic [7:0] d);
    if (which == 4) begin
      if4.in_valid = v;
      if4.in_sel   = s;
      if4.in_data  = d;
    end else begin
      if1.in_valid = v;
      if1.in_sel   = s;
      if1.in_data  = d;
    end
  endtask

  // Observed {tx_out, tx_busy, frame_done, in_ready}.
  function automatic logic [3:0] obs(input int which);
    if (which == 4) return {tx_out4, tx_busy4, fd4, if4.in_ready};
    return {tx_out1, tx_busy1, fd1, if1.in_ready};
  endfunction

  task automatic check_outs(input int which, input string tag, input logic [3:0] exp);
    logic [3:0] o;
    string      t;
    o = obs(which);
    t = $sformatf("%s.c%0d", tag, which);
    chk({t, ".tx_out"},     8'(o[3]), 8'(exp[3]));
    chk({t, ".tx_busy"},    8'(o[2]), 8'(exp[2]));
    chk({t, ".frame_done"}, 8'(o[1]), 8'(exp[1]));
    chk({t, ".in_ready"},   8'(o[0]), 8'(exp[0]));
  endtask

  // Called #1 after the accepting edge. Checks every frame cycle while
  // scrambling the inputs, then the single idle cycle, where the next request
  // (nv/ns/nd) is presented. abort_n stops at the start of that frame cycle.
  task automatic check_frame(input int which, input logic [2:0] s, input logic [7:0] d,
                             input logic keep_valid, input int abort_n,
                             input logic nv, input logic [2:0] ns, input logic [7:0] nd);
    logic [13:0] f;
    int          c;
    f = model_frame(s, d);
    c = which;
    for (int n = 1; n <= 14 * c; n++) begin
      if (abort_n != 0 && n == abort_n) return;
      check_outs(which, $sformatf("frame_n%0d", n), {f[(n - 1) / c], 1'b1, (n == 14 * c), 1'b0});
      set_in(which, keep_valid, 3'($urandom), 8'($urandom));
      @(posedge clk); #1;
    end
    check_outs(which, "gap", 4'b1001);
    set_in(which, nv, ns, nd);
    @(posedge clk); #1;
  endtask

  task automatic start_frame(input int which, input logic [2:0] s, input logic [7:0] d,
                             input logic keep_valid);
    set_in(which, 1'b1, s, d);
    @(posedge clk); #1;
    check_frame(which, s, d, keep_valid, 0, 1'b0, 3'd0, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] s0, s1, s2;
    logic [7:0] d0, d1, d2;

    rst = 1'b1;
    set_in(4, 1'b0, 3'd0, 8'd0);
    set_in(1, 1'b0, 3'd0, 8'd0);

    // Reset values while rst is held.
    repeat (3) begin
      @(posedge clk); #1;
      check_outs(4, "reset", 4'b1000);
      check_outs(1, "reset", 4'b1000);
    end

    // Release: ready in the first cycle after deassertion, then 10 idle cycles.
    rst = 1'b0;
    #1;
    check_outs(4, "post_reset", 4'b1001);
    check_outs(1, "post_reset", 4'b1001);
    repeat (10) begin
      @(posedge clk); #1;
      check_outs(4, "idle", 4'b1001);
      check_outs(1, "idle", 4'b1001);
    end

    // Directed frames at 4 clocks/bit.
    start_frame(4, 3'b010, 8'hA5, 1'b0);
    start_frame(4, 3'b111, 8'hFF, 1'b0);
    start_frame(4, 3'b000, 8'h00, 1'b0);

    // in_valid kept high with changing data while the frame is in flight.
    start_frame(4, 3'($urandom), 8'($urandom), 1'b1);

    // Back-to-back frames at 1 clock/bit with in_valid held high.
    s0 = 3'($urandom); d0 = 8'($urandom);
    s1 = 3'($urandom); d1 = 8'($urandom);
    s2 = 3'($urandom); d2 = 8'($urandom);
    set_in(1, 1'b1, s0, d0);
    @(posedge clk); #1;
    check_frame(1, s0, d0, 1'b1, 0, 1'b1, s1, d1);
    check_frame(1, s1, d1, 1'b1, 0, 1'b1, s2, d2);
    check_frame(1, s2, d2, 1'b1, 0, 1'b0, 3'd0, 8'd0);
    check_outs(1, "after_b2b", 4'b1001);

    // Reset during DATA bit 4 (frame bit 8, cycles 33..36 at 4 clocks/bit),
    // with in_valid offered in the reset cycle as well.
    s0 = 3'($urandom); d0 = 8'($urandom);
    set_in(4, 1'b1, s0, d0);
    @(posedge clk); #1;
    check_frame(4, s0, d0, 1'b0, 34, 1'b0, 3'd0, 8'd0);
    rst = 1'b1;
    set_in(4, 1'b1, 3'($urandom), 8'($urandom));
    @(posedge clk); #1;
    check_outs(4, "abort", 4'b1000);
    rst = 1'b0;
    set_in(4, 1'b0, 3'd0, 8'd0);
    #1;
    check_outs(4, "abort_release", 4'b1001);
    repeat (10) begin
      @(posedge clk); #1;
      check_outs(4, "abort_idle", 4'b1001);
    end
    start_frame(4, 3'($urandom), 8'($urandom), 1'b0);

    // Random frames on both instances.
    for (int i = 0; i < 4; i++) begin
      start_frame(4, 3'($urandom), 8'($urandom), 1'($urandom));
      start_frame(1, 3'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
